// File: rtl/seat_alloc_ctrl_pkg.sv
// Shared types and sizing for the seat booking controller and its helpers.
package seat_pkg;

  localparam int N_SEATS = 5;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    ACK
  } state_t;

  typedef enum logic {
    GATE0 = 1'b0,
    GATE1 = 1'b1
  } gate_t;

  function automatic logic [IDX_W-1:0] popcount(input logic [N_SEATS-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_SEATS; i++) begin
      c = c + IDX_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/seat_alloc_ctrl_if.sv
// Booking handshake between the two entry gates and the seat controller.
interface seat_alloc_ctrl_if;
  import seat_pkg::*;

  logic [1:0]       i_req;
  logic [1:0]       o_ack;
  logic             o_ok;
  logic [IDX_W-1:0] o_seat_idx;

  modport master (output i_req, input o_ack, input o_ok, input o_seat_idx);
  modport slave  (input i_req, output o_ack, output o_ok, output o_seat_idx);

endinterface

// File: rtl/seat_alloc_ctrl_find_free.sv
// Lowest-zero priority encoder over the occupancy vector.
module seat_find_free
  import seat_pkg::*;
(
  input  logic [N_SEATS-1:0] occ_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               none_free_o
);

  // Scan from the top down so the lowest free seat is the last one written.
  always_comb begin
    idx_o       = '0;
    none_free_o = 1'b1;
    for (int i = N_SEATS - 1; i >= 0; i--) begin
      if (!occ_i[i]) begin
        idx_o       = IDX_W'(i);
        none_free_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seat_alloc_ctrl.sv
// Seat booking controller: two-gate round-robin allocation, release checking,
// and registered occupancy/count/full/empty status.
module seat_alloc_ctrl
  import seat_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  seat_alloc_ctrl_if.slave    bk,
  input  logic                i_rel_vld,
  input  logic [IDX_W-1:0]    i_rel_idx,
  output logic                o_rel_err,
  output logic [N_SEATS-1:0]  o_seat,
  output logic [IDX_W-1:0]    o_count,
  output logic                o_full,
  output logic                o_empty
);

  state_t              state_q, state_d;
  gate_t               rr_q, rr_d;
  gate_t               win_q, win_d;
  logic                ok_q, ok_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_SEATS-1:0]  occ_q, occ_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                relErr_q, relErr_d;

  logic [IDX_W-1:0]    freeIdx;
  logic                noneFree;
  logic [N_SEATS-1:0]  relMask;
  logic [N_SEATS-1:0]  relApplied;
  logic [N_SEATS-1:0]  allocMask;
  logic                relHit;

  seat_find_free u_find_free (
    .occ_i       (occ_q),
    .idx_o       (freeIdx),
    .none_free_o (noneFree)
  );

  // Out-of-range indices give an empty mask, so they can never hit a taken seat.
  assign relMask    = (i_rel_idx < IDX_W'(N_SEATS)) ? (N_SEATS'(1) << i_rel_idx) : '0;
  assign relHit     = |(occ_q & relMask);
  assign relApplied = (i_rel_vld && relHit) ? relMask : '0;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    ok_d      = ok_q;
    idx_d     = idx_q;
    allocMask = '0;
    relErr_d  = i_rel_vld && !relHit;

    case (state_q)
      IDLE: begin
        if (|bk.i_req) begin
          state_d = ALLOC;
          if (bk.i_req == 2'b11) begin
            win_d = rr_q;
          end else begin
            win_d = bk.i_req[1] ? GATE1 : GATE0;
          end
        end
      end
      ALLOC: begin
        state_d = ACK;
        rr_d    = (win_q == GATE0) ? GATE1 : GATE0;
        ok_d    = !noneFree;
        idx_d   = noneFree ? '0 : freeIdx;
        if (!noneFree) begin
          allocMask = N_SEATS'(1) << freeIdx;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Release and allocation never touch the same bit: one is taken, one free.
    occ_d   = (occ_q & ~relApplied) | allocMask;
    count_d = popcount(occ_d);
    full_d  = (count_d == IDX_W'(N_SEATS));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      rr_q     <= GATE0;
      win_q    <= GATE0;
      ok_q     <= 1'b0;
      idx_q    <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      relErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      ok_q     <= ok_d;
      idx_q    <= idx_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      relErr_q <= relErr_d;
    end
  end

  assign bk.o_ack      = (state_q == ACK) ? (2'b01 << win_q) : 2'b00;
  assign bk.o_ok       = (state_q == ACK) && ok_q;
  assign bk.o_seat_idx = ((state_q == ACK) && ok_q) ? idx_q : '0;
  assign o_rel_err     = relErr_q;
  assign o_seat        = occ_q;
  assign o_count       = count_q;
  assign o_full        = full_q;
  assign o_empty       = empty_q;

endmodule

// File: tb/tb_seat_alloc_ctrl.sv
// Scoreboard bench for seat_alloc_ctrl: bookings push expected acks, a monitor pops them.
module tb_seat_alloc_ctrl;
  import seat_pkg::*;

  typedef struct {
    logic [1:0] ack;
    logic       ok;
    logic [2:0] idx;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               rel_vld;
  logic [IDX_W-1:0]   rel_idx;
  logic               rel_err;
  logic [N_SEATS-1:0] seat;
  logic [IDX_W-1:0]   count;
  logic               full;
  logic               empty;

  seat_alloc_ctrl_if bk ();

  seat_alloc_ctrl dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bk        (bk),
    .i_rel_vld (rel_vld),
    .i_rel_idx (rel_idx),
    .o_rel_err (rel_err),
    .o_seat    (seat),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty)
  );

  int   errors = 0;
  int   checks = 0;
  int   cycleCnt = 0;
  exp_t expq[$];
  int   ackCycles[$];
  exp_t monE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Ack monitor: every ack seen must match the oldest expected booking.
  always @(negedge clk) begin
    cycleCnt++;
    if (bk.o_ack !== 2'b00) begin
      ackCycles.push_back(cycleCnt);
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("[TB] FAIL ack_unexpected: got ack=%b ok=%b idx=%0d, required no ack",
                 bk.o_ack, bk.o_ok, bk.o_seat_idx);
      end else begin
        monE = expq.pop_front();
        if (bk.o_ack !== monE.ack || bk.o_ok !== monE.ok || bk.o_seat_idx !== monE.idx) begin
          errors++;
          $display("[TB] FAIL ack_scoreboard: got ack=%b ok=%b idx=%0d, required ack=%b ok=%b idx=%0d",
                   bk.o_ack, bk.o_ok, bk.o_seat_idx, monE.ack, monE.ok, monE.idx);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    bk.i_req = 2'b00;
    rel_vld  = 1'b0;
    rel_idx  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Stimulus only: queue the expectation, hold req until ack (bounded), then idle a cycle.
  task automatic book(input int gate, input logic expOk, input logic [2:0] expIdx, output int waited);
    exp_t e;
    e.ack = 2'b01 << gate;
    e.ok  = expOk;
    e.idx = expIdx;
    expq.push_back(e);
    bk.i_req[gate] = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bk.o_ack[gate] !== 1'b1 && waited < 10);
    bk.i_req[gate] = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_seat(input logic [IDX_W-1:0] idx);
    rel_vld = 1'b1;
    rel_idx = idx;
    @(negedge clk);
    rel_vld = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (seat !== 5'b00000) begin errors++; $display("[TB] FAIL reset_seat: got %b, required 00000", seat); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d, required 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b, required 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b, required 0", full); end
    checks++; if (bk.o_ack !== 2'b00) begin errors++; $display("[TB] FAIL reset_ack: got %b, required 00", bk.o_ack); end
    checks++; if (bk.o_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_ok: got %b, required 0", bk.o_ok); end
    checks++; if (bk.o_seat_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d, required 0", bk.o_seat_idx); end
    checks++; if (rel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rel_err: got %b, required 0", rel_err); end
  endtask

  task automatic test_fill();
    int w;
    for (int i = 0; i < 5; i++) begin
      book(0, 1'b1, 3'(i), w);
      checks++;
      if (w !== 2) begin errors++; $display("[TB] FAIL fill_latency[%0d]: got %0d cycles, required 2", i, w); end
    end
    checks++; if (seat !== 5'b11111) begin errors++; $display("[TB] FAIL fill_seat: got %b, required 11111", seat); end
    checks++; if (count !== 3'd5) begin errors++; $display("[TB] FAIL fill_count: got %0d, required 5", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %b, required 1", full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty: got %b, required 0", empty); end
  endtask

  task automatic test_reject();
    int w;
    book(1, 1'b0, 3'd0, w);
    checks++; if (w !== 2) begin errors++; $display("[TB] FAIL reject_latency: got %0d, required 2", w); end
    checks++; if (seat !== 5'b11111) begin errors++; $display("[TB] FAIL reject_seat: got %b, required 11111", seat); end
    release_seat(3'd2);
    checks++; if (seat !== 5'b11011) begin errors++; $display("[TB] FAIL release2_seat: got %b, required 11011", seat); end
    checks++; if (count !== 3'd4 || full !== 1'b0) begin errors++; $display("[TB] FAIL release2_count: got %0d full=%b, required 4 full=0", count, full); end
    checks++; if (rel_err !== 1'b0) begin errors++; $display("[TB] FAIL release2_err: got %b, required 0", rel_err); end
    book(1, 1'b1, 3'd2, w);
    checks++; if (seat !== 5'b11111) begin errors++; $display("[TB] FAIL rebook_seat: got %b, required 11111", seat); end
  endtask

  task automatic test_release_err();
    int w;
    do_reset();
    for (int i = 0; i < 3; i++) book(0, 1'b1, 3'(i), w);
    release_seat(3'd3);
    checks++; if (rel_err !== 1'b1) begin errors++; $display("[TB] FAIL relerr_free: got %b, required 1", rel_err); end
    checks++; if (seat !== 5'b00111 || count !== 3'd3) begin errors++; $display("[TB] FAIL relerr_free_state: got %b/%0d, required 00111/3", seat, count); end
    @(negedge clk);
    checks++; if (rel_err !== 1'b0) begin errors++; $display("[TB] FAIL relerr_pulse: got %b, required 0", rel_err); end
    release_seat(3'd6);
    checks++; if (rel_err !== 1'b1) begin errors++; $display("[TB] FAIL relerr_idx6: got %b, required 1", rel_err); end
    checks++; if (seat !== 5'b00111 || count !== 3'd3) begin errors++; $display("[TB] FAIL relerr_idx6_state: got %b/%0d, required 00111/3", seat, count); end
    release_seat(3'd5);
    checks++; if (rel_err !== 1'b1) begin errors++; $display("[TB] FAIL relerr_idx5: got %b, required 1", rel_err); end
    release_seat(3'd1);
    checks++; if (rel_err !== 1'b0) begin errors++; $display("[TB] FAIL relok_err: got %b, required 0", rel_err); end
    checks++; if (seat !== 5'b00101 || count !== 3'd2) begin errors++; $display("[TB] FAIL relok_state: got %b/%0d, required 00101/2", seat, count); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n0, n1;
    bit reraise0;
    rst_n    = 1'b0;
    rel_vld  = 1'b0;
    bk.i_req = 2'b11;
    @(negedge clk);
    @(negedge clk);
    ackCycles.delete();
    e.ok = 1'b1;
    e.ack = 2'b01; e.idx = 3'd0; expq.push_back(e);
    e.ack = 2'b10; e.idx = 3'd1; expq.push_back(e);
    e.ack = 2'b01; e.idx = 3'd2; expq.push_back(e);
    rst_n = 1'b1;
    n0 = 0; n1 = 0; reraise0 = 1'b0;
    for (int k = 0; k < 30 && !(n0 == 2 && n1 == 1); k++) begin
      @(negedge clk);
      if (reraise0) begin bk.i_req[0] = 1'b1; reraise0 = 1'b0; end
      if (bk.o_ack[0] === 1'b1) begin n0++; bk.i_req[0] = 1'b0; reraise0 = (n0 < 2); end
      if (bk.o_ack[1] === 1'b1) begin n1++; bk.i_req[1] = 1'b0; end
    end
    bk.i_req = 2'b00;
    @(negedge clk);
    checks++; if (n0 !== 2 || n1 !== 1) begin errors++; $display("[TB] FAIL b2b_counts: got g0=%0d g1=%0d, required g0=2 g1=1", n0, n1); end
    checks++;
    if (ackCycles.size() == 3) begin
      if (ackCycles[1] - ackCycles[0] !== 3 || ackCycles[2] - ackCycles[1] !== 3) begin
        errors++;
        $display("[TB] FAIL b2b_spacing: got %0d,%0d cycles, required 3,3",
                 ackCycles[1] - ackCycles[0], ackCycles[2] - ackCycles[1]);
      end
    end else begin
      errors++;
      $display("[TB] FAIL b2b_spacing: got %0d acks, required 3", ackCycles.size());
    end
    checks++; if (seat !== 5'b00111) begin errors++; $display("[TB] FAIL b2b_seat: got %b, required 00111", seat); end
  endtask

  task automatic test_same_edge();
    exp_t e;
    int w;
    do_reset();
    for (int i = 0; i < 5; i++) book(0, 1'b1, 3'(i), w);
    e.ack = 2'b10; e.ok = 1'b0; e.idx = 3'd0; expq.push_back(e);
    bk.i_req[1] = 1'b1;
    @(negedge clk);
    rel_vld = 1'b1;
    rel_idx = 3'd0;
    @(negedge clk);
    rel_vld = 1'b0;
    checks++; if (bk.o_ack !== 2'b10 || bk.o_ok !== 1'b0) begin errors++; $display("[TB] FAIL same_edge_ack: got ack=%b ok=%b, required ack=10 ok=0", bk.o_ack, bk.o_ok); end
    bk.i_req[1] = 1'b0;
    checks++; if (seat !== 5'b11110 || count !== 3'd4) begin errors++; $display("[TB] FAIL same_edge_seat: got %b/%0d, required 11110/4", seat, count); end
    @(negedge clk);
    book(0, 1'b1, 3'd0, w);
    checks++; if (seat !== 5'b11111) begin errors++; $display("[TB] FAIL same_edge_rebook: got %b, required 11111", seat); end
  endtask

  task automatic test_reset_mid();
    int w;
    int acksBefore;
    do_reset();
    book(0, 1'b1, 3'd0, w);
    book(0, 1'b1, 3'd1, w);
    bk.i_req[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    bk.i_req[0] = 1'b0;
    @(negedge clk);
    acksBefore = ackCycles.size();
    checks++; if (seat !== 5'b00000 || count !== 3'd0) begin errors++; $display("[TB] FAIL midreset_seat: got %b/%0d, required 00000/0", seat, count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got empty=%b full=%b, required empty=1 full=0", empty, full); end
    checks++; if (bk.o_ack !== 2'b00 || bk.o_ok !== 1'b0 || bk.o_seat_idx !== 3'd0) begin errors++; $display("[TB] FAIL midreset_ack: got ack=%b ok=%b idx=%0d, required 00/0/0", bk.o_ack, bk.o_ok, bk.o_seat_idx); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ackCycles.size() !== acksBefore) begin errors++; $display("[TB] FAIL midreset_noack: got %0d acks, required %0d", ackCycles.size(), acksBefore); end
  endtask

  initial begin
    rst_n    = 1'b0;
    bk.i_req = 2'b00;
    rel_vld  = 1'b0;
    rel_idx  = '0;
    test_reset();
    test_fill();
    test_reject();
    test_release_err();
    test_back_to_back();
    test_same_edge();
    test_reset_mid();
    checks++;
    if (expq.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seat_alloc_ctrl.md
# seat_alloc_ctrl

Booking controller for the seat counter: holds the seat-occupancy vector that feeds the seat-counter LED display and arbitrates seat bookings from two entry gates. It frees seats on request and reports occupancy count, full and empty. Each booking returns either the lowest-numbered free seat or a reject, through a req/ack handshake with round-robin fairness between the gates.

## Interface
- N_SEATS, 5, number of seats; must not exceed 7.
- IDX_W, 3, seat index / count width.

- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- i_req  in  2  booking request per gate; held high until that gate's o_ack.
- o_ack  out  2  one-cycle acknowledge per gate; at most one bit high.
- o_ok  out  1  qualifies o_ack: 1 = seat granted, 0 = rejected (full).
- o_seat_idx  out  IDX_W  granted seat index, valid when o_ack!=0 and o_ok=1, else 0.
- i_rel_vld  in  1  one-cycle release strobe.
- i_rel_idx  in  IDX_W  seat to free, sampled with i_rel_vld.
- o_rel_err  out  1  one-cycle pulse: release of a free seat, or index >= N_SEATS.
- o_seat  out  N_SEATS  occupancy vector, bit i = seat i taken; drives seat-counter i_seat.
- o_count  out  IDX_W  number of taken seats.
- o_full  out  1  o_count == N_SEATS.
- o_empty  out  1  o_count == 0.

## Operation
- FSM states: IDLE, ALLOC, ACK.
  - IDLE -> ALLOC when any i_req bit is high. Latch the winning gate; all other states ignore i_req.
  - ALLOC -> ACK always. The winning gate's seat is set here.
  - ACK -> IDLE always. o_ack and o_ok are high during ACK only.
- Arbitration: round-robin pointer rr.
  - If only one gate requests, it wins.
  - If both request, gate rr wins.
  - rr moves to the other gate after every serviced request, granted or rejected.
- Allocation in ALLOC uses occupancy at the start of the cycle.
  - Pick the lowest free index; set its bit; o_ok=1.
  - If no seat is free: o_ok=0, o_seat_idx=0, occupancy unchanged.
- Release is independent of the FSM and applied at the edge ending the i_rel_vld cycle.
  - Invalid release (seat already free, or index >= N_SEATS): occupancy unchanged, o_rel_err pulses the next cycle.
- Same-edge release and allocation: next occupancy = (occ & ~rel_mask) | alloc_mask.
  - A seat freed in the ALLOC cycle is not visible to that allocation. If the block was full, that booking is rejected.
- o_count, o_full and o_empty are registered together with o_seat, so they are always consistent with it in the same cycle.

## Timing
- Reset (i_rst_n low at an edge): state IDLE, rr=0, o_seat=0, o_count=0, o_empty=1, o_full=0. o_ack, o_ok, o_seat_idx and o_rel_err are all 0.
- Reset mid-operation aborts any pending booking; no ack is issued. The requester must re-request.
- Latency: i_req first high in cycle T (FSM in IDLE) -> ALLOC in T+1 -> o_ack, o_ok, o_seat_idx and the updated o_seat all visible in T+2.
- Gate handshake:
  - The gate must drop i_req by the edge ending its ack cycle.
  - The FSM returns to IDLE in T+3 and samples i_req again there, so back-to-back bookings take 3 cycles each.
- A request arriving while the FSM is busy waits, held high, until IDLE.
- Release: i_rel_vld in cycle T -> o_seat/o_count updated in T+1; o_rel_err (if any) in T+1.

## Structure
- Package seat_pkg holds N_SEATS, IDX_W, the FSM state typedef (IDLE/ALLOC/ACK) and a gate-id typedef.
- Sub-module seat_find_free: combinational lowest-zero priority encoder over occupancy.
  - Outputs the free index and a none-free flag.
  - Shared with future seat blocks.
- Top module holds the FSM, rr pointer, occupancy/count registers and release checking.

## Test plan
- Reset, then gate 0 books 5 times -> seats 0,1,2,3,4 granted in order; o_count=5, o_full=1, o_seat=5'b11111.
- Full, gate 1 books -> o_ack=2'b10 with o_ok=0; o_seat unchanged. Release seat 2, rebook -> seat 2 granted.
- Both gates hold i_req from reset -> acks alternate gate0, gate1, gate0, with 3 cycles between acks.
- Release of free seat 3, and release index 6 -> o_rel_err pulses each time; o_seat/o_count unchanged.
- Full, release of seat 0 in the same cycle the FSM is in ALLOC -> booking rejected, seat 0 freed. Next booking gets seat 0.
- i_rst_n low during ALLOC with 2 seats taken -> next cycle all outputs 0, o_empty=1, no o_ack.
